serv_seq: RTL
=============

SERV_SEQ -- requirements
Module: serv_seq

Interface
REQ-001 SHALL have parameter W, default 1, meaning datapath bits processed per cycle; legal values 1, 2, 4 and 8; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter MDU_HOLD, default 0, meaning that when 1, RUN stalls while i_mdu_busy is high.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; i_rst input 1, synchronous active-high reset.
REQ-004 i_ibus_ack  input  1  pulse: new instruction latched by the decoder this cycle.
REQ-005 i_two_stage  input  1  current instruction needs an INIT pass (branch, slt, jal, jalr, mem, shift).
REQ-006 i_mem_op  input  1  current instruction is a load or store.
REQ-007 i_e_op  input  1  current instruction is ecall or ebreak.
REQ-008 i_dbus_ack  input  1  data bus transfer complete.
REQ-009 i_mem_misalign  input  1  data address misaligned; sampled at end of INIT.
REQ-010 i_jump, i_ctrl_misalign  input  1 each  taken jump, and target misaligned; sampled at end of INIT.
REQ-011 i_mdu_busy  input  1  multi-cycle unit not ready; used only when MDU_HOLD=1.
REQ-012 o_ibus_active  output  1  state is IDLE.
REQ-013 o_init, o_run, o_trap  output  1 each  one-hot state decodes.
REQ-014 o_cnt_en  output  1  state is not IDLE and the phase is not stalled.
REQ-015 o_cnt  output  5  bit index of the LSB of the current beat.
REQ-016 o_cnt_done  output  1  last beat of the current phase.
REQ-017 o_cnt_lt8, o_cnt_lt16  output  1 each  o_cnt<8 and o_cnt<16; byte and half lane valids.
REQ-018 o_dbus_cyc  output  1  data bus request outstanding.

Function
REQ-019 States SHALL be IDLE, INIT, RUN and TRAP; state SHALL be encoded in 2 bits; o_init, o_run and o_trap SHALL never be high together.
REQ-020 go SHALL be a register set to i_ibus_ack on every cycle; an i_ibus_ack received outside IDLE SHALL NOT cause a transition.
REQ-021 In IDLE with go=1, the next state SHALL be: TRAP if i_e_op; else INIT if i_two_stage; else RUN.
REQ-022 In IDLE with i_dbus_ack=1 (load data return), the next state SHALL be RUN; this SHALL take priority over go.
REQ-023 At INIT with o_cnt_done=1, the next state SHALL be: TRAP if i_mem_misalign or (i_jump and i_ctrl_misalign); else IDLE if i_mem_op; else RUN.
REQ-024 At RUN or TRAP with o_cnt_done=1, the next state SHALL be IDLE.
REQ-025 o_cnt SHALL increment by W on each cycle with o_cnt_en=1, wrap modulo 32, and hold in IDLE.
REQ-026 o_cnt_done SHALL equal (o_cnt == 32-W) and o_cnt_en; each phase SHALL last exactly 32/W enabled cycles.
REQ-027 With MDU_HOLD=1, RUN with i_mdu_busy=1 SHALL deassert o_cnt_en and hold o_cnt and state; INIT and TRAP SHALL never stall.
REQ-028 o_dbus_cyc SHALL be set on the INIT->IDLE transition for a mem op.
REQ-029 o_dbus_cyc SHALL clear on the cycle after i_dbus_ack.
REQ-030 o_dbus_cyc SHALL never be set on a misalign trap.
REQ-031 i_dbus_ack with o_dbus_cyc=0 SHALL be ignored.
REQ-032 o_cnt_lt8 and o_cnt_lt16 SHALL be combinational from o_cnt.
REQ-033 All other outputs SHALL be combinational decodes of registered state; no input-to-output combinational path SHALL exist except i_mdu_busy->o_cnt_en.

Reset
REQ-034 On i_rst=1 at a clock edge: state=IDLE, o_cnt=0, go=0, o_dbus_cyc=0; o_ibus_active=1 in the following cycle.
REQ-035 Reset SHALL take effect in any state and at any o_cnt value, including mid-phase and with a bus cycle outstanding; inputs during reset SHALL be ignored.

Verification
REQ-036 W=1, ALU op (i_two_stage=0): i_ibus_ack pulse -> RUN two cycles later, 32 cycles of o_cnt_en, o_cnt 0..31, then IDLE.
REQ-037 W=4, load: two_stage=1 and mem_op=1 -> INIT for 8 cycles (o_cnt 0,4..28) -> IDLE with o_dbus_cyc=1 -> ack -> RUN for 8 cycles -> IDLE, o_dbus_cyc=0.
REQ-038 W=1, store with i_mem_misalign=1 at INIT end -> TRAP for 32 cycles, o_dbus_cyc never high -> IDLE.
REQ-039 W=8, ecall: i_e_op=1 -> TRAP directly from IDLE for 4 cycles -> IDLE; o_cnt_lt8=1 only on the first beat.
REQ-040 MDU_HOLD=1, W=2: i_mdu_busy held 5 cycles at o_cnt=6 -> o_cnt frozen at 6, RUN totals 21 cycles; a second run asserts i_rst at o_cnt=10 -> IDLE and o_cnt=0 next cycle.

Source files
------------

// File: rtl/serv_seq.sv
// serv_seq: bit-serial instruction sequencer.
// Walks each instruction through IDLE -> [INIT] -> RUN/TRAP -> IDLE, producing
// the beat counter that steps the serial datapath W bits per cycle and the
// data-bus request flag for loads and stores.
module serv_seq #(
  parameter int W        = 1,
  parameter int MDU_HOLD = 0
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_ibus_ack,
  input  logic       i_two_stage,
  input  logic       i_mem_op,
  input  logic       i_e_op,
  input  logic       i_dbus_ack,
  input  logic       i_mem_misalign,
  input  logic       i_jump,
  input  logic       i_ctrl_misalign,
  input  logic       i_mdu_busy,
  output logic       o_ibus_active,
  output logic       o_init,
  output logic       o_run,
  output logic       o_trap,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic       o_cnt_lt8,
  output logic       o_cnt_lt16,
  output logic       o_dbus_cyc
);

  // Only power-of-two widths that divide 32 are meaningful.
  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
      $error("serv_seq: W must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    TRAP = 2'd3
  } state_t;

  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);

  state_t     state, state_nxt;
  logic       go;
  logic [4:0] cnt;
  logic       dbus_cyc;
  logic       stall;
  logic       cnt_en;
  logic       cnt_done;
  logic       misalign_trap;
  logic       dbus_set;
  logic       dbus_ret;

  // Next-state decode, phase enable and bus-request conditions.
  always_comb begin
    state_nxt     = state;
    stall         = (MDU_HOLD != 0) && (state == RUN) && i_mdu_busy;
    cnt_en        = (state != IDLE) && !stall;
    cnt_done      = cnt_en && (cnt == LAST);
    misalign_trap = i_mem_misalign || (i_jump && i_ctrl_misalign);
    dbus_ret      = dbus_cyc && i_dbus_ack;
    dbus_set      = 1'b0;
    unique case (state)
      IDLE: begin
        // A load data return resumes the instruction ahead of a new fetch.
        if (dbus_ret)
          state_nxt = RUN;
        else if (go)
          state_nxt = i_e_op ? TRAP : (i_two_stage ? INIT : RUN);
      end
      INIT: begin
        if (cnt_done) begin
          if (misalign_trap)
            state_nxt = TRAP;
          else if (i_mem_op) begin
            state_nxt = IDLE;
            dbus_set  = 1'b1;
          end else
            state_nxt = RUN;
        end
      end
      RUN, TRAP: begin
        if (cnt_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, fetch strobe, beat counter and bus request registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= IDLE;
      go       <= 1'b0;
      cnt      <= '0;
      dbus_cyc <= 1'b0;
    end else begin
      state <= state_nxt;
      go    <= i_ibus_ack;
      if (cnt_en)
        cnt <= cnt + STEP;
      if (dbus_ret)
        dbus_cyc <= 1'b0;
      else if (dbus_set)
        dbus_cyc <= 1'b1;
    end
  end

  // Output decodes.
  always_comb begin
    o_ibus_active = (state == IDLE);
    o_init        = (state == INIT);
    o_run         = (state == RUN);
    o_trap        = (state == TRAP);
    o_cnt_en      = cnt_en;
    o_cnt         = cnt;
    o_cnt_done    = cnt_done;
    o_cnt_lt8     = (cnt < 5'd8);
    o_cnt_lt16    = (cnt < 5'd16);
    o_dbus_cyc    = dbus_cyc;
  end

endmodule
